// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control slice.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_SW  = 7'd35;
  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_I   = 7'd19;
  localparam logic [6:0] OP_BEQ = 7'd99;
  localparam logic [6:0] OP_JAL = 7'd111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, not on the phase.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control <-> datapath bundle: instruction fields and flags in, selects and enables out.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       pc_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal;
  logic       mem_fault;
  logic [3:0] state_dbg;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, adr_src, ir_write, mem_write, reg_write, pc_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control,
           illegal, mem_fault, state_dbg
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, adr_src, ir_write, mem_write, reg_write, pc_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control,
           illegal, mem_fault, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl_aludec.sv
// ALU decoder carried over from the single-cycle control unit.
module multicycle_ctrl_aludec (
  input  logic       opb5,
  input  logic       funct7b5,
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  output logic [2:0] alu_control
);

  logic rtype_sub;
  assign rtype_sub = opb5 & funct7b5;

  // Map ALUOp/funct fields onto the ALU operation code.
  always_comb begin
    alu_control = 3'b000;
    case (aluop)
      2'b00: alu_control = 3'b000;
      2'b01: alu_control = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alu_control = rtype_sub ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencing FSM with memory-ready wait, timeout and sticky traps.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   FETCH    | read instruction at PC, PC+4 into PC on mem_ready
//   DECODE   | compute branch target, dispatch on opcode
//   MEMADR   | rs1 + imm address for lw/sw
//   MEMREAD  | load access, wait for mem_ready
//   MEMWB    | write loaded data to register file
//   MEMWRITE | store access, mem_write held until mem_ready
//   EXECR    | R-type ALU op on rs1, rs2
//   EXECI    | I-type ALU op on rs1, imm
//   ALUWB    | write ALUOut to register file
//   BEQ      | compare rs1/rs2, take branch on zero
//   JAL      | jump to target, PC+4 kept for link writeback
//   TRAP     | absorbing; illegal opcode or memory timeout
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input logic clk,
  input logic reset_n,
  multicycle_ctrl_if.master bus
);

  state_t          state, state_next;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit, mem_wait;
  logic            illegal_q, fault_q, illegal_set, fault_set;

  logic       mem_req_c, adr_src_c, ir_write_c, mem_write_c, reg_write_c;
  logic       pc_update, branch;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, aluop;

  assign timeout_hit = (MEM_TIMEOUT != 0) && (to_cnt == TO_W'(MEM_TIMEOUT));
  assign mem_wait    = ((state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE))
                       && !bus.mem_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_next;
  end

  // Wait counter: counts stalled cycles in a memory state, clears on any progress or state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      to_cnt <= '0;
    else if ((MEM_TIMEOUT != 0) && mem_wait && (state_next == state))
      to_cnt <= to_cnt + TO_W'(1);
    else
      to_cnt <= '0;
  end

  // Sticky trap flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      illegal_q <= illegal_q | illegal_set;
      fault_q   <= fault_q | fault_set;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_next   = state;
    mem_req_c    = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    pc_update    = 1'b0;
    branch       = 1'b0;
    result_src_c = RES_ALUOUT;
    alu_src_a_c  = SRCA_PC;
    alu_src_b_c  = SRCB_RS2;
    aluop        = ALUOP_ADD;
    illegal_set  = 1'b0;
    fault_set    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALURESULT;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_update  = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          fault_set  = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            state_next  = S_TRAP;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        state_next  = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (bus.mem_ready) begin
          state_next = S_MEMWB;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          fault_set  = 1'b1;
        end
      end
      S_MEMWB: begin
        result_src_c = RES_DATA;
        reg_write_c  = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        if (bus.mem_ready) begin
          state_next = S_FETCH;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          fault_set  = 1'b1;
        end
      end
      S_EXECR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_RS2;
        aluop       = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        aluop       = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_RS2;
        aluop       = ALUOP_SUB;
        branch      = 1'b1;
        state_next  = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_FOUR;
        pc_update   = 1'b1;
        state_next  = S_ALUWB;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  multicycle_ctrl_aludec u_aludec (
    .opb5        (bus.op[5]),
    .funct7b5    (bus.funct7b5),
    .aluop       (aluop),
    .funct3      (bus.funct3),
    .alu_control (bus.alu_control)
  );

  // Enables are forced low while reset is held so nothing leaks out of FETCH during reset.
  assign bus.mem_req    = reset_n & mem_req_c;
  assign bus.ir_write   = reset_n & ir_write_c;
  assign bus.mem_write  = reset_n & mem_write_c;
  assign bus.reg_write  = reset_n & reg_write_c;
  assign bus.pc_write   = reset_n & (pc_update | (branch & bus.zero));
  assign bus.adr_src    = adr_src_c;
  assign bus.result_src = result_src_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.imm_src    = imm_src_of(bus.op);
  assign bus.illegal    = illegal_q;
  assign bus.mem_fault  = fault_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction reference model builds the
// expected per-cycle control vector from the instruction class and memory wait lengths.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  typedef logic [22:0] vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  vec_t exp_q[$];
  bit   rdy_q[$];
  bit   zro_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [6:0] ops_ok[6]  = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111};
  logic [6:0] ops_bad[5] = '{7'd0, 7'd127, 7'd23, 7'd55, 7'd103};
  logic [2:0] f3_tab[4]  = '{3'd0, 3'd2, 3'd6, 3'd7};

  function automatic vec_t obs();
    return {bus.state_dbg, bus.mem_req, bus.adr_src, bus.ir_write, bus.mem_write,
            bus.reg_write, bus.pc_write, bus.result_src, bus.alu_src_a, bus.alu_src_b,
            bus.alu_control, bus.imm_src, bus.illegal, bus.mem_fault};
  endfunction

  function automatic vec_t mk(input logic [3:0] st, input bit mreq, input bit adr,
                              input bit irw, input bit mw, input bit rw, input bit pcw,
                              input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                              input logic [2:0] alu, input logic [1:0] imm,
                              input bit ill, input bit flt);
    return {st, mreq, adr, irw, mw, rw, pcw, rs, a, b, alu, imm, ill, flt};
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input vec_t v, input bit r, input bit z);
    exp_q.push_back(v);
    rdy_q.push_back(r);
    zro_q.push_back(z);
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] op);
    if (op == 7'd35)  return 2'b01;
    if (op == 7'd99)  return 2'b10;
    if (op == 7'd111) return 2'b11;
    return 2'b00;
  endfunction

  // ALU operation the instruction asks for: add/sub/slt/or/and.
  function automatic logic [2:0] exp_alu(input logic [6:0] op, input logic [2:0] f3, input bit f7);
    case (f3)
      3'd0:    return (op == 7'd51 && f7) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic void trap_tail(input logic [1:0] imm, input bit ill, input bit flt, input int n);
    for (int i = 0; i < n; i++)
      push(mk(4'd11, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, imm, ill, flt), rnd(), rnd());
  endfunction

  // A memory phase lasts w stalled cycles then one ready cycle, unless w exceeds the
  // timeout: then TO+1 stalled cycles precede the trap.
  function automatic bit mem_phase(input vec_t vw, input vec_t vd, input int w, input logic [1:0] imm);
    int nw;
    nw = (w > TO) ? TO + 1 : w;
    for (int i = 0; i < nw; i++) push(vw, 1'b0, rnd());
    if (w > TO) begin
      trap_tail(imm, 1'b0, 1'b1, 3);
      return 1'b1;
    end
    push(vd, 1'b1, rnd());
    return 1'b0;
  endfunction

  // Expected cycle sequence for one instruction; returns 1 if it ends in TRAP.
  function automatic bit model_instr(input logic [6:0] op, input logic [2:0] f3, input bit f7,
                                     input bit z, input int wf, input int wm);
    logic [1:0] imm;
    logic [3:0] mst;
    vec_t       vw;
    imm = exp_imm(op);
    if (mem_phase(mk(4'd0, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, imm, 0, 0),
                  mk(4'd0, 1, 0, 1, 0, 0, 1, 2'd2, 2'd0, 2'd2, 3'd0, imm, 0, 0), wf, imm))
      return 1'b1;
    push(mk(4'd1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, imm, 0, 0), rnd(), rnd());
    case (op)
      7'd3, 7'd35: begin
        push(mk(4'd2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, imm, 0, 0), rnd(), rnd());
        mst = (op == 7'd3) ? 4'd3 : 4'd5;
        vw  = mk(mst, 1, 1, 0, (op == 7'd35), 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, imm, 0, 0);
        if (mem_phase(vw, vw, wm, imm)) return 1'b1;
        if (op == 7'd3)
          push(mk(4'd4, 0, 0, 0, 0, 1, 0, 2'd1, 2'd0, 2'd0, 3'd0, imm, 0, 0), rnd(), rnd());
      end
      7'd51, 7'd19: begin
        push(mk((op == 7'd51) ? 4'd6 : 4'd7, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2,
                (op == 7'd51) ? 2'd0 : 2'd1, exp_alu(op, f3, f7), imm, 0, 0), rnd(), rnd());
        push(mk(4'd8, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, imm, 0, 0), rnd(), rnd());
      end
      7'd99:
        push(mk(4'd9, 0, 0, 0, 0, 0, z, 2'd0, 2'd2, 2'd0, 3'd1, imm, 0, 0), rnd(), z);
      7'd111: begin
        push(mk(4'd10, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd2, 3'd0, imm, 0, 0), rnd(), rnd());
        push(mk(4'd8, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, imm, 0, 0), rnd(), rnd());
      end
      default: begin
        trap_tail(imm, 1'b1, 1'b0, 3);
        return 1'b1;
      end
    endcase
    return 1'b0;
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input bit f7);
    bus.op = op;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (bus.state_dbg !== 4'd0) begin
        n_fail++; $display("FAIL reset_state got=%0d want=0", bus.state_dbg);
      end
      n_chk++;
      if ({bus.mem_req, bus.ir_write, bus.mem_write, bus.reg_write, bus.pc_write} !== 5'b0) begin
        n_fail++; $display("FAIL reset_enables got=%b want=00000",
          {bus.mem_req, bus.ir_write, bus.mem_write, bus.reg_write, bus.pc_write});
      end
      n_chk++;
      if ({bus.illegal, bus.mem_fault} !== 2'b00) begin
        n_fail++; $display("FAIL reset_traps got=%b want=00", {bus.illegal, bus.mem_fault});
      end
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_rtype();
    vec_t v; int c; int nrw;
    c = 0; nrw = 0;
    set_instr(7'd51, 3'd0, 1'b0);
    void'(model_instr(7'd51, 3'd0, 1'b0, 1'b0, 0, 0));
    while (exp_q.size() != 0) begin
      v = exp_q.pop_front(); bus.mem_ready = rdy_q.pop_front(); bus.zero = zro_q.pop_front();
      #1; n_chk++;
      if (obs() !== v) begin
        n_fail++; $display("FAIL rtype_path cyc=%0d got=%h want=%h", c, obs(), v);
      end
      if (bus.reg_write) nrw++;
      c++; @(posedge clk); #1;
    end
    n_chk++;
    if (nrw !== 1) begin n_fail++; $display("FAIL rtype_regwrite_count got=%0d want=1", nrw); end
    n_chk++;
    if (bus.state_dbg !== 4'd0) begin
      n_fail++; $display("FAIL rtype_return got=%0d want=0", bus.state_dbg);
    end
  endtask

  task automatic test_lw_wait();
    vec_t v; int c; int nrd;
    c = 0; nrd = 0;
    set_instr(7'd3, 3'd2, 1'b0);
    void'(model_instr(7'd3, 3'd2, 1'b0, 1'b0, 1, 3));
    while (exp_q.size() != 0) begin
      v = exp_q.pop_front(); bus.mem_ready = rdy_q.pop_front(); bus.zero = zro_q.pop_front();
      #1; n_chk++;
      if (obs() !== v) begin
        n_fail++; $display("FAIL lw_path cyc=%0d got=%h want=%h", c, obs(), v);
      end
      if (bus.state_dbg == 4'd3) nrd++;
      c++; @(posedge clk); #1;
    end
    n_chk++;
    if (nrd !== 4) begin n_fail++; $display("FAIL lw_memread_cycles got=%0d want=4", nrd); end
  endtask

  task automatic test_beq();
    vec_t v; int c;
    for (int zz = 1; zz >= 0; zz--) begin
      c = 0;
      set_instr(7'd99, 3'd0, 1'b0);
      void'(model_instr(7'd99, 3'd0, 1'b0, zz[0], 0, 0));
      while (exp_q.size() != 0) begin
        v = exp_q.pop_front(); bus.mem_ready = rdy_q.pop_front(); bus.zero = zro_q.pop_front();
        #1; n_chk++;
        if (obs() !== v) begin
          n_fail++; $display("FAIL beq_z%0d_path cyc=%0d got=%h want=%h", zz, c, obs(), v);
        end
        c++; @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jal();
    vec_t v; int c; int npc;
    c = 0; npc = 0;
    set_instr(7'd111, 3'd5, 1'b1);
    void'(model_instr(7'd111, 3'd5, 1'b1, 1'b0, 0, 0));
    while (exp_q.size() != 0) begin
      v = exp_q.pop_front(); bus.mem_ready = rdy_q.pop_front(); bus.zero = zro_q.pop_front();
      #1; n_chk++;
      if (obs() !== v) begin
        n_fail++; $display("FAIL jal_path cyc=%0d got=%h want=%h", c, obs(), v);
      end
      if (bus.pc_write) npc++;
      c++; @(posedge clk); #1;
    end
    n_chk++;
    if (npc !== 2) begin n_fail++; $display("FAIL jal_pcwrite_count got=%0d want=2", npc); end
  endtask

  task automatic test_illegal();
    vec_t v; int c;
    c = 0;
    set_instr(7'd0, 3'd0, 1'b0);
    void'(model_instr(7'd0, 3'd0, 1'b0, 1'b0, 0, 0));
    trap_tail(2'b00, 1'b1, 1'b0, 20);
    while (exp_q.size() != 0) begin
      v = exp_q.pop_front(); bus.mem_ready = rdy_q.pop_front(); bus.zero = zro_q.pop_front();
      #1; n_chk++;
      if (obs() !== v) begin
        n_fail++; $display("FAIL illegal_path cyc=%0d got=%h want=%h", c, obs(), v);
      end
      c++; @(posedge clk); #1;
    end
    do_reset();
    n_chk++;
    if ({bus.state_dbg, bus.illegal} !== 5'b0000_0) begin
      n_fail++; $display("FAIL illegal_cleared got=%0d/%b want=0/0", bus.state_dbg, bus.illegal);
    end
  endtask

  task automatic test_timeout();
    vec_t v; int c; int nmw;
    c = 0; nmw = 0;
    set_instr(7'd35, 3'd2, 1'b0);
    void'(model_instr(7'd35, 3'd2, 1'b0, 1'b0, 0, 9));
    while (exp_q.size() != 0) begin
      v = exp_q.pop_front(); bus.mem_ready = rdy_q.pop_front(); bus.zero = zro_q.pop_front();
      #1; n_chk++;
      if (obs() !== v) begin
        n_fail++; $display("FAIL timeout_path cyc=%0d got=%h want=%h", c, obs(), v);
      end
      if (bus.mem_write) nmw++;
      c++; @(posedge clk); #1;
    end
    n_chk++;
    if (nmw !== TO + 1) begin
      n_fail++; $display("FAIL timeout_memwrite_cycles got=%0d want=%0d", nmw, TO + 1);
    end
    do_reset();
    c = 0;
    void'(model_instr(7'd35, 3'd2, 1'b0, 1'b0, 0, TO));
    while (exp_q.size() != 0) begin
      v = exp_q.pop_front(); bus.mem_ready = rdy_q.pop_front(); bus.zero = zro_q.pop_front();
      #1; n_chk++;
      if (obs() !== v) begin
        n_fail++; $display("FAIL expiry_ready_path cyc=%0d got=%h want=%h", c, obs(), v);
      end
      c++; @(posedge clk); #1;
    end
    n_chk++;
    if ({bus.state_dbg, bus.mem_fault} !== 5'b0000_0) begin
      n_fail++; $display("FAIL expiry_ready_nofault got=%0d/%b want=0/0", bus.state_dbg, bus.mem_fault);
    end
  endtask

  task automatic test_reset_mid();
    vec_t v;
    set_instr(7'd35, 3'd2, 1'b0);
    void'(model_instr(7'd35, 3'd2, 1'b0, 1'b0, 0, 3));
    for (int i = 0; i < 5; i++) begin
      v = exp_q.pop_front(); bus.mem_ready = rdy_q.pop_front(); bus.zero = zro_q.pop_front();
      #1; n_chk++;
      if (obs() !== v) begin
        n_fail++; $display("FAIL midreset_path cyc=%0d got=%h want=%h", i, obs(), v);
      end
      @(posedge clk); #1;
    end
    exp_q.delete(); rdy_q.delete(); zro_q.delete();
    bus.mem_ready = 1'b0;
    reset_n = 1'b0;
    #1; n_chk++;
    if ({bus.state_dbg, bus.mem_write, bus.mem_req} !== 6'b0000_00) begin
      n_fail++; $display("FAIL midreset_abort got=%0d/%b/%b want=0/0/0",
        bus.state_dbg, bus.mem_write, bus.mem_req);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1; n_chk++;
    if ({bus.state_dbg, bus.mem_write, bus.mem_req} !== 6'b0000_01) begin
      n_fail++; $display("FAIL midreset_resume got=%0d/%b/%b want=0/0/1",
        bus.state_dbg, bus.mem_write, bus.mem_req);
    end
  endtask

  task automatic test_random();
    vec_t v; int c; bit trapped;
    logic [6:0] op; logic [2:0] f3; bit f7; int wf; int wm;
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? ops_bad[$urandom_range(0, 4)] : ops_ok[$urandom_range(0, 5)];
      f3 = f3_tab[$urandom_range(0, 3)];
      f7 = rnd();
      wf = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, TO));
      wm = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(0, TO));
      set_instr(op, f3, f7);
      trapped = model_instr(op, f3, f7, rnd(), wf, wm);
      c = 0;
      while (exp_q.size() != 0) begin
        v = exp_q.pop_front(); bus.mem_ready = rdy_q.pop_front(); bus.zero = zro_q.pop_front();
        #1; n_chk++;
        if (obs() !== v) begin
          n_fail++;
          $display("FAIL random_path n=%0d op=%0d cyc=%0d got=%h want=%h", n, op, c, obs(), v);
        end
        c++; @(posedge clk); #1;
      end
      if (trapped) do_reset();
    end
  endtask

  initial begin
    bus.op = 7'd51;
    bus.funct3 = 3'd0;
    bus.funct7b5 = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_jal();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

endmodule
